// File: rtl/bcd_serial_sub.sv
// bcd_serial_sub: digit-serial packed-BCD subtractor, one digit per clock, LSD first.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - request a subtraction (honoured only while idle)
//   a, b  - minuend / subtrahend, packed BCD, digit 0 in [3:0]
//   bin   - borrow in, applied at digit 0
//   d     - BCD difference (10's complement when negative)
//   bout  - borrow out of the most significant digit
//   busy  - high while digits are being processed
//   done  - one-cycle completion pulse
//   err   - an accepted operand digit was greater than 9
module bcd_serial_sub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic [4*DIGITS-1:0]   d,
    output logic                  bout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
    state_t         state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic           borrow;
    logic [IW-1:0]  idx;
    logic signed [5:0] t;
    logic           neg;
    logic [3:0]     dig;
    logic           bad;
    // Operands shift right each cycle so the current digit is always [3:0];
    // result digits enter acc from the top so the LSD ends up at [3:0].
    always_comb begin
        t       = 6'(op_a[3:0]) - 6'(op_b[3:0]) - 6'(borrow);
        neg     = t < 0;
        dig     = neg ? 4'(t + 6'sd10) : t[3:0];
        acc_nxt = W'({dig, acc} >> 4);
    end
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_a   <= a;
                    op_b   <= b;
                    borrow <= bin;
                    idx    <= '0;
                    acc    <= '0;
                    err    <= bad;
                    busy   <= 1'b1;
                    state  <= SUB;
                end
                SUB: begin
                    op_a   <= op_a >> 4;
                    op_b   <= op_b >> 4;
                    borrow <= neg;
                    acc    <= acc_nxt;
                    idx    <= idx + 1'b1;
                    if (idx == IW'(DIGITS - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= acc_nxt;
                        bout  <= neg;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_sub.sv
// tb_bcd_serial_sub: directed and randomized checks of bcd_serial_sub against a decimal-arithmetic model.
module tb_bcd_serial_sub;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;
    logic         done;
    logic         err;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    bcd_serial_sub #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .d(d), .bout(bout), .busy(busy), .done(done), .err(err)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction
    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] ed, output logic eb);
        int diff = bcd2int(ma) - bcd2int(mb) - int'(mbin);
        eb = diff < 0;
        if (eb) diff += 10 ** DIGITS;
        ed = int2bcd(diff);
    endtask
    // Runs one operation, scrambling inputs after acceptance and optionally
    // pulsing start mid-operation, which must be ignored.
    task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                      input logic [W-1:0] ed, input logic eb, input logic ee,
                      input bit chk_d, input bit poke);
        @(negedge clk);
        a = oa; b = ob; bin = obin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        check("busy_first", busy, 1);
        check("err_latched", err, ee);
        for (int n = 2; n <= DIGITS; n++) begin
            @(negedge clk);
            start = (poke && n == 2);
            check("busy_sub", busy, 1);
            check("done_early", done, 0);
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("err_done", err, ee);
        if (chk_d) begin
            check("d", d, ed);
            check("bout", bout, eb);
        end
        @(negedge clk);
        check("done_single", done, 0);
        check("busy_idle", busy, 0);
        if (chk_d) check("d_hold", d, ed);
    endtask
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask
    initial begin
        logic [W-1:0] ra, rb, ed;
        logic         rbin, eb, inv;
        int           n;
        #12;
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 1, 0);
        op(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1, 1);
        op(16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0, 1, 0);
        op(16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0, 1, 1);
        op(16'h12A4, 16'h0001, 1'b0, 16'h12A3, 1'b0, 1'b1, 1, 0);
        op(16'h0010, 16'h0001, 1'b1, 16'h0008, 1'b0, 1'b0, 1, 0);
        repeat (30) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rbin = 1'($urandom);
            inv = $urandom_range(0, 5) == 0;
            if (inv) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            model(ra, rb, rbin, ed, eb);
            op(ra, rb, rbin, ed, eb, inv, !inv, 1'($urandom));
        end
        op(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1, 0);
        @(negedge clk);
        a = 16'h12A4; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_pre_err", err, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_d", d, 0);
        check("arst_bout", bout, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIGITS + 2) begin
            @(negedge clk);
            check("abort_done", done, 0);
            check("abort_busy", busy, 0);
        end
        op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 1, 0);
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200;
        check("held_busy", busy, 1);
        wait_done(n);
        check("held_lat1", n, DIGITS + 1);
        check("held_d1", d, 16'h3087);
        check("held_bout1", bout, 0);
        @(negedge clk);
        check("held_idle_busy", busy, 0);
        check("held_idle_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        check("held_relaunch", busy, 1);
        wait_done(n);
        check("held_lat2", n, DIGITS + 1);
        check("held_d2", d, 16'h9900);
        check("held_bout2", bout, 1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
